// File: rtl/dram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter_if
//   Bundles every signal between the DataRAM port arbiter, its two requesters
//   (ControllerSeq data path on port 0, I/O DMA engine on port 1) and the
//   DataRAM memoryModule.
//
//   Signal groups
//     p0_* / p1_*  requester side: req/we/ind/addr/wdata in, ack/err out
//     rdata        read data returned to whichever port holds ack
//     mem_*        DataRAM command bus (cntrl/addr/din/ind out, dout/ready in)
//     busy, owner  arbiter status
//
//   Modports
//     slave   the arbiter itself
//     master  the environment: both requesters plus the memory
// ---------------------------------------------------------------------------
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic              p0_ind;
  logic              p1_ind;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_ack;
  logic              p1_ack;
  logic              p0_err;
  logic              p1_err;
  logic [DATA_W-1:0] rdata;

  logic [1:0]        mem_cntrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_ind;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ready;

  logic              busy;
  logic              owner;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_ind, p1_ind,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_ack, p1_ack, p0_err, p1_err, rdata,
    output mem_cntrl, mem_addr, mem_din, mem_ind,
    input  mem_dout, mem_ready,
    output busy, owner
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_ind, p1_ind,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_ack, p1_ack, p0_err, p1_err, rdata,
    input  mem_cntrl, mem_addr, mem_din, mem_ind,
    output mem_dout, mem_ready,
    input  busy, owner
  );

endinterface

// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//   Shares the single DataRAM port between two requesters using round-robin
//   arbitration and a four-phase req/ack handshake per port. The memory
//   command is held until dataReady returns; a watchdog aborts an access that
//   never completes and reports it through the winner's err flag.
//
//   Parameters
//     ADDR_W   address width (DataRAM addrSize)
//     DATA_W   data width (DataRAM ramWidth)
//     TO_W     timeout counter width
//     TIMEOUT  BUSY cycles without mem_ready before abort (1..2^TO_W-1)
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    dram_port_arbiter_if.slave: requester handshakes, DataRAM
//            command bus, busy/owner status
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  dram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arbState_e;

  // The abort fires on the edge that ends the TIMEOUT-th BUSY cycle, i.e.
  // when the counter (cleared at grant) still reads TIMEOUT-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

  arbState_e         state;
  arbState_e         stateNext;

  // lastGrant doubles as the owner output: it is the port being served while
  // busy and the most recent winner while idle.
  logic              lastGrant;
  logic              latWe;
  logic              latInd;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [DATA_W-1:0] rdataReg;
  logic [TO_W-1:0]   toCnt;
  logic              p0AckReg;
  logic              p1AckReg;
  logic              p0ErrReg;
  logic              p1ErrReg;

  logic              winner;
  logic              ownReq;
  logic              doGrant;
  logic              doFinish;
  logic              timedOut;
  logic              doRelease;

  // On a tie the port that did not win last time is served; otherwise the
  // lone requester wins (p1_req alone selects port 1, p0_req alone port 0).
  assign winner = (bus.p0_req && bus.p1_req) ? ~lastGrant : bus.p1_req;

  // Only the granted port's req keeps the arbiter in DONE; the loser's req
  // is simply left pending until the next IDLE.
  assign ownReq = lastGrant ? bus.p1_req : bus.p0_req;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and the one-cycle strobes that steer the datapath.
  // mem_ready beats the watchdog when both land on the same edge, and DONE
  // waits for mem_ready to fall so a slow memory cannot leak its ready into
  // the next access.
  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    doFinish  = 1'b0;
    timedOut  = 1'b0;
    doRelease = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          doGrant   = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          doFinish  = 1'b1;
          stateNext = DONE;
        end else if (toCnt == TO_LAST) begin
          doFinish  = 1'b1;
          timedOut  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!ownReq && !bus.mem_ready) begin
          doRelease = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: request latch at grant, saturating watchdog counter, read-data
  // capture and the per-port ack/err flags. Reset discards any latched
  // request so a half-done access is never resumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastGrant <= 1'b1;
      latWe     <= 1'b0;
      latInd    <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      rdataReg  <= '0;
      toCnt     <= '0;
      p0AckReg  <= 1'b0;
      p1AckReg  <= 1'b0;
      p0ErrReg  <= 1'b0;
      p1ErrReg  <= 1'b0;
    end else begin
      if (doGrant) begin
        lastGrant <= winner;
        latWe     <= winner ? bus.p1_we    : bus.p0_we;
        latInd    <= winner ? bus.p1_ind   : bus.p0_ind;
        latAddr   <= winner ? bus.p1_addr  : bus.p0_addr;
        latWdata  <= winner ? bus.p1_wdata : bus.p0_wdata;
        toCnt     <= '0;
      end else if (state == BUSY && toCnt != TO_MAX) begin
        toCnt <= toCnt + TO_W'(1);
      end

      // Writes and aborted accesses leave the previous read data in place.
      if (doFinish) begin
        if (!timedOut && !latWe) begin
          rdataReg <= bus.mem_dout;
        end
        if (lastGrant) begin
          p1AckReg <= 1'b1;
          p1ErrReg <= timedOut;
        end else begin
          p0AckReg <= 1'b1;
          p0ErrReg <= timedOut;
        end
      end

      if (doRelease) begin
        p0AckReg <= 1'b0;
        p1AckReg <= 1'b0;
        p0ErrReg <= 1'b0;
        p1ErrReg <= 1'b0;
      end
    end
  end

  // The command is only asserted in BUSY, so an async reset (which forces
  // IDLE) drops it immediately. Address/data/indirect simply follow the
  // latch, which is stable from grant until the next grant.
  assign bus.mem_cntrl = (state == BUSY) ? (latWe ? 2'b01 : 2'b10) : 2'b00;
  assign bus.mem_addr  = latAddr;
  assign bus.mem_din   = latWdata;
  assign bus.mem_ind   = latInd;

  assign bus.rdata     = rdataReg;
  assign bus.p0_ack    = p0AckReg;
  assign bus.p1_ack    = p1AckReg;
  assign bus.p0_err    = p0ErrReg;
  assign bus.p1_err    = p1ErrReg;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = lastGrant;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_port_arbiter
//   Directed bench for dram_port_arbiter with a short watchdog (TIMEOUT=4).
//   A small DataRAM model answers each command after memLatency BUSY cycles
//   (0 = never answers) and returns readValue on reads.
// ---------------------------------------------------------------------------
module tb_dram_port_arbiter;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  // Memory model controls (written by the test sequence only).
  int         memLatency;
  logic [7:0] readValue;
  // Memory model state (written by the model only).
  int         memCount;
  logic [7:0] lastWriteAddr;
  logic [7:0] lastWriteData;

  dram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) dif ();

  dram_port_arbiter #(
    .ADDR_W (8),
    .DATA_W (8),
    .TO_W   (8),
    .TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataRAM model: counts cycles the command is asserted and raises ready
  // in the memLatency-th one; ready drops once the command goes idle.
  always @(negedge clk) begin
    if (dif.mem_cntrl == 2'b00) begin
      dif.mem_ready = 1'b0;
      memCount      = 0;
    end else if (dif.mem_ready !== 1'b1) begin
      memCount++;
      if (memLatency != 0 && memCount == memLatency) begin
        if (dif.mem_cntrl == 2'b01) begin
          lastWriteAddr = dif.mem_addr;
          lastWriteData = dif.mem_din;
        end else begin
          dif.mem_dout = readValue;
        end
        dif.mem_ready = 1'b1;
      end
    end
  end

  // Hard stop in case a wait somewhere is not bounded as intended.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic clearPorts();
    dif.p0_req = 1'b0;  dif.p1_req = 1'b0;
    dif.p0_we  = 1'b0;  dif.p1_we  = 1'b0;
    dif.p0_ind = 1'b0;  dif.p1_ind = 1'b0;
    dif.p0_addr = 8'h00; dif.p1_addr = 8'h00;
    dif.p0_wdata = 8'h00; dif.p1_wdata = 8'h00;
  endtask

  task automatic applyReset();
    clearPorts();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for the arbiter to return to IDLE.
  task automatic waitIdle(output bit ok);
    int guard;
    guard = 0;
    while (dif.busy !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    ok = (dif.busy === 1'b0);
  endtask

  task automatic test_reset();
    clearPorts();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_cntrl} !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL reset_status: got busy/owner/cntrl=%b expected 0100",
               {dif.busy, dif.owner, dif.mem_cntrl});
    end
    testsRun++;
    if ({dif.mem_addr, dif.mem_din, dif.mem_ind, dif.rdata} !== 25'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: got addr=%h din=%h ind=%b rdata=%h expected all 0",
               dif.mem_addr, dif.mem_din, dif.mem_ind, dif.rdata);
    end
    testsRun++;
    if ({dif.p0_ack, dif.p1_ack, dif.p0_err, dif.p1_err} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_acks: got %b expected 0000",
               {dif.p0_ack, dif.p1_ack, dif.p0_err, dif.p1_err});
    end
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: got busy/owner=%b expected 01", {dif.busy, dif.owner});
    end
  endtask

  // Both ports keep requesting: grants must go 0, 1, 0.
  task automatic test_arbitration();
    int guard;
    bit ok;
    applyReset();
    memLatency = 2;
    readValue  = 8'h11;
    dif.p0_req = 1'b1; dif.p0_addr = 8'h01;
    dif.p1_req = 1'b1; dif.p1_addr = 8'h02;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_addr} !== {2'b10, 8'h01}) begin
      testsFailed++;
      $display("[TB] FAIL arb_first: got busy=%b owner=%b addr=%h expected 1 0 01",
               dif.busy, dif.owner, dif.mem_addr);
    end
    guard = 0;
    while (dif.p0_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    testsRun++;
    if ({dif.p0_ack, dif.p1_ack, dif.rdata} !== {2'b10, 8'h11}) begin
      testsFailed++;
      $display("[TB] FAIL arb_first_ack: got p0_ack=%b p1_ack=%b rdata=%h expected 1 0 11",
               dif.p0_ack, dif.p1_ack, dif.rdata);
    end
    dif.p0_req = 1'b0;
    guard = 0;
    while (dif.p0_ack !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    dif.p0_req = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_addr} !== {2'b11, 8'h02}) begin
      testsFailed++;
      $display("[TB] FAIL arb_second: got busy=%b owner=%b addr=%h expected 1 1 02",
               dif.busy, dif.owner, dif.mem_addr);
    end
    guard = 0;
    while (dif.p1_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    testsRun++;
    if ({dif.p1_ack, dif.p0_ack} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL arb_second_ack: got p1_ack=%b p0_ack=%b expected 1 0",
               dif.p1_ack, dif.p0_ack);
    end
    dif.p1_req = 1'b0;
    guard = 0;
    while (dif.p1_ack !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    dif.p1_req = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_addr} !== {2'b10, 8'h01}) begin
      testsFailed++;
      $display("[TB] FAIL arb_third: got busy=%b owner=%b addr=%h expected 1 0 01",
               dif.busy, dif.owner, dif.mem_addr);
    end
    dif.p1_req = 1'b0;
    guard = 0;
    while (dif.p0_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    dif.p0_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL arb_idle: got busy=%b expected 0", dif.busy);
    end
  endtask

  task automatic test_read();
    int guard;
    int cmdCycles;
    bit ok;
    memLatency = 3;
    readValue  = 8'hA5;
    dif.p0_req = 1'b1; dif.p0_we = 1'b0; dif.p0_addr = 8'h10;
    cmdCycles = 0;
    guard = 0;
    do begin
      @(negedge clk);
      if (dif.mem_cntrl == 2'b10) cmdCycles++;
      guard++;
    end while (dif.p0_ack !== 1'b1 && guard < 20);
    testsRun++;
    if (cmdCycles != 3) begin
      testsFailed++;
      $display("[TB] FAIL read_cmd_cycles: got %0d expected 3", cmdCycles);
    end
    testsRun++;
    if ({dif.p0_ack, dif.p0_err, dif.rdata} !== {2'b10, 8'hA5}) begin
      testsFailed++;
      $display("[TB] FAIL read_ack: got ack=%b err=%b rdata=%h expected 1 0 a5",
               dif.p0_ack, dif.p0_err, dif.rdata);
    end
    testsRun++;
    if ({dif.mem_cntrl, dif.busy} !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL read_done: got cntrl=%b busy=%b expected 00 1", dif.mem_cntrl, dif.busy);
    end
    dif.p0_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if ({ok, dif.p0_ack} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL read_release: got idle=%b ack=%b expected 1 0", ok, dif.p0_ack);
    end
  endtask

  task automatic test_write();
    int guard;
    int cmdCycles;
    bit ok;
    memLatency = 3;
    dif.p1_req = 1'b1; dif.p1_we = 1'b1; dif.p1_addr = 8'h20; dif.p1_wdata = 8'h3C;
    cmdCycles = 0;
    guard = 0;
    do begin
      @(negedge clk);
      if (dif.mem_cntrl == 2'b01) begin
        cmdCycles++;
        testsRun++;
        if ({dif.mem_addr, dif.mem_din} !== 16'h203C) begin
          testsFailed++;
          $display("[TB] FAIL write_bus_stable: got addr=%h din=%h expected 20 3c",
                   dif.mem_addr, dif.mem_din);
        end
      end
      guard++;
    end while (dif.p1_ack !== 1'b1 && guard < 20);
    testsRun++;
    if (cmdCycles != 3) begin
      testsFailed++;
      $display("[TB] FAIL write_cmd_cycles: got %0d expected 3", cmdCycles);
    end
    testsRun++;
    if ({dif.p1_ack, dif.p1_err, dif.owner, dif.rdata} !== {3'b101, 8'hA5}) begin
      testsFailed++;
      $display("[TB] FAIL write_ack: got ack=%b err=%b owner=%b rdata=%h expected 1 0 1 a5",
               dif.p1_ack, dif.p1_err, dif.owner, dif.rdata);
    end
    testsRun++;
    if ({lastWriteAddr, lastWriteData} !== 16'h203C) begin
      testsFailed++;
      $display("[TB] FAIL write_mem: got addr=%h data=%h expected 20 3c", lastWriteAddr, lastWriteData);
    end
    dif.p1_req = 1'b0; dif.p1_we = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL write_release: got busy=%b expected 0", dif.busy);
    end
  endtask

  // Memory never answers: abort after exactly 4 BUSY cycles.
  task automatic test_timeout();
    int guard;
    int cmdCycles;
    bit ok;
    memLatency = 0;
    dif.p0_req = 1'b1; dif.p0_we = 1'b0; dif.p0_addr = 8'h30;
    cmdCycles = 0;
    guard = 0;
    do begin
      @(negedge clk);
      if (dif.mem_cntrl == 2'b10) cmdCycles++;
      guard++;
    end while (dif.p0_ack !== 1'b1 && guard < 20);
    testsRun++;
    if (cmdCycles != 4) begin
      testsFailed++;
      $display("[TB] FAIL timeout_cycles: got %0d expected 4", cmdCycles);
    end
    testsRun++;
    if ({dif.p0_ack, dif.p0_err, dif.mem_cntrl, dif.rdata} !== {4'b1100, 8'hA5}) begin
      testsFailed++;
      $display("[TB] FAIL timeout_ack: got ack=%b err=%b cntrl=%b rdata=%h expected 1 1 00 a5",
               dif.p0_ack, dif.p0_err, dif.mem_cntrl, dif.rdata);
    end
    dif.p0_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if ({ok, dif.p0_err} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL timeout_release: got idle=%b err=%b expected 1 0", ok, dif.p0_err);
    end
  endtask

  // Ready arrives in the very cycle the watchdog would fire: ready wins.
  task automatic test_ready_at_timeout();
    int guard;
    int cmdCycles;
    bit ok;
    memLatency = 4;
    readValue  = 8'h5A;
    dif.p1_req = 1'b1; dif.p1_we = 1'b0; dif.p1_addr = 8'h31;
    cmdCycles = 0;
    guard = 0;
    do begin
      @(negedge clk);
      if (dif.mem_cntrl == 2'b10) cmdCycles++;
      guard++;
    end while (dif.p1_ack !== 1'b1 && guard < 20);
    testsRun++;
    if ({cmdCycles == 4, dif.p1_ack, dif.p1_err, dif.rdata} !== {3'b110, 8'h5A}) begin
      testsFailed++;
      $display("[TB] FAIL ready_at_timeout: got cycles=%0d ack=%b err=%b rdata=%h expected 4 1 0 5a",
               cmdCycles, dif.p1_ack, dif.p1_err, dif.rdata);
    end
    dif.p1_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ready_at_timeout_release: got busy=%b expected 0", dif.busy);
    end
  endtask

  // Requester gives up mid-access: access completes, ack pulses one cycle.
  task automatic test_req_drop();
    int guard;
    memLatency = 3;
    readValue  = 8'hC3;
    dif.p0_req = 1'b1; dif.p0_we = 1'b0; dif.p0_addr = 8'h44;
    @(negedge clk);
    dif.p0_req = 1'b0;
    guard = 0;
    while (dif.p0_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    testsRun++;
    if ({dif.p0_ack, dif.p0_err, dif.rdata} !== {2'b10, 8'hC3}) begin
      testsFailed++;
      $display("[TB] FAIL drop_ack: got ack=%b err=%b rdata=%h expected 1 0 c3",
               dif.p0_ack, dif.p0_err, dif.rdata);
    end
    @(negedge clk);
    testsRun++;
    if ({dif.p0_ack, dif.busy} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL drop_pulse: got ack=%b busy=%b expected 0 0", dif.p0_ack, dif.busy);
    end
  endtask

  task automatic test_reset_mid_access();
    int guard;
    bit ok;
    memLatency = 0;
    dif.p0_req = 1'b1; dif.p0_we = 1'b0; dif.p0_addr = 8'h55;
    repeat (2) @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.mem_cntrl} !== 3'b110) begin
      testsFailed++;
      $display("[TB] FAIL midreset_pre: got busy=%b cntrl=%b expected 1 10", dif.busy, dif.mem_cntrl);
    end
    #1;
    reset = 1'b0;
    #1;
    testsRun++;
    if ({dif.mem_cntrl, dif.busy, dif.p0_ack, dif.p1_ack, dif.owner} !== 6'b000001) begin
      testsFailed++;
      $display("[TB] FAIL midreset_async: got cntrl=%b busy=%b acks=%b%b owner=%b expected 00 0 00 1",
               dif.mem_cntrl, dif.busy, dif.p0_ack, dif.p1_ack, dif.owner);
    end
    testsRun++;
    if ({dif.rdata, dif.mem_addr} !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL midreset_clear: got rdata=%h addr=%h expected 00 00", dif.rdata, dif.mem_addr);
    end
    dif.p0_req = 1'b0;
    memLatency = 2;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dif.p0_req = 1'b1; dif.p1_req = 1'b1; dif.p1_addr = 8'h66;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_addr} !== {2'b10, 8'h55}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_tie: got busy=%b owner=%b addr=%h expected 1 0 55",
               dif.busy, dif.owner, dif.mem_addr);
    end
    dif.p1_req = 1'b0;
    guard = 0;
    while (dif.p0_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    dif.p0_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_release: got busy=%b expected 0", dif.busy);
    end
  endtask

  // p0 keeps req high after ack; pending p1 waits until p0 lets go.
  task automatic test_hold_after_ack();
    int guard;
    bit ok;
    memLatency = 2;
    readValue  = 8'h77;
    dif.p0_req = 1'b1; dif.p0_we = 1'b0; dif.p0_addr = 8'h40;
    @(negedge clk);
    dif.p1_req = 1'b1; dif.p1_we = 1'b0; dif.p1_addr = 8'h50;
    guard = 0;
    while (dif.p0_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      testsRun++;
      if ({dif.busy, dif.owner, dif.p0_ack, dif.p1_ack, dif.mem_cntrl} !== 6'b101000) begin
        testsFailed++;
        $display("[TB] FAIL hold_done[%0d]: got busy=%b owner=%b acks=%b%b cntrl=%b expected 1 0 10 00",
                 i, dif.busy, dif.owner, dif.p0_ack, dif.p1_ack, dif.mem_cntrl);
      end
    end
    dif.p0_req = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.p0_ack} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL hold_idle: got busy=%b ack=%b expected 0 0", dif.busy, dif.p0_ack);
    end
    @(negedge clk);
    testsRun++;
    if ({dif.busy, dif.owner, dif.mem_cntrl, dif.mem_addr} !== {4'b1110, 8'h50}) begin
      testsFailed++;
      $display("[TB] FAIL hold_p1_grant: got busy=%b owner=%b cntrl=%b addr=%h expected 1 1 10 50",
               dif.busy, dif.owner, dif.mem_cntrl, dif.mem_addr);
    end
    guard = 0;
    while (dif.p1_ack !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    testsRun++;
    if ({dif.p1_ack, dif.rdata} !== {1'b1, 8'h77}) begin
      testsFailed++;
      $display("[TB] FAIL hold_p1_ack: got ack=%b rdata=%h expected 1 77", dif.p1_ack, dif.rdata);
    end
    dif.p1_req = 1'b0;
    waitIdle(ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_release: got busy=%b expected 0", dif.busy);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    memLatency  = 3;
    readValue   = 8'h00;
    reset       = 1'b0;
    clearPorts();

    test_reset();
    test_arbitration();
    test_read();
    test_write();
    test_timeout();
    test_ready_at_timeout();
    test_req_drop();
    test_reset_mid_access();
    test_hold_after_ack();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
